// File: rtl/ifu_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch_queue
// Purpose  : Instruction-fetch front end. It holds the fetch PC and drives a
//            1-cycle synchronous instruction-memory read. Returned words pass
//            through static prediction into a DEPTH-entry prefetch queue,
//            which feeds decode over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module ifu_fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter int unsigned     IMEM_AW  = 14,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter bit              BTFN_EN  = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_en,
  output logic [IMEM_AW-1:0]         imem_addr,
  input  logic [31:0]                imem_rdata,
  input  logic                       flush_flag,
  input  logic [XLEN-1:0]            flush_addr,
  input  logic                       dec_ready,
  output logic                       inst_valid,
  output logic [31:0]                inst,
  output logic [XLEN-1:0]            inst_pc,
  output logic                       inst_pred_taken,
  output logic [XLEN-1:0]            inst_pred_pc,
  output logic [$clog2(DEPTH+1)-1:0] fq_count
);

  localparam int unsigned     C_PTR_W     = $clog2(DEPTH);
  localparam int unsigned     C_CNT_W     = $clog2(DEPTH + 1);
  localparam logic [6:0]      C_OP_JAL    = 7'b1101111;
  localparam logic [6:0]      C_OP_BRANCH = 7'b1100011;
  localparam logic [XLEN-1:0] C_PC_STEP   = XLEN'(4);

  // Fetch state
  logic [XLEN-1:0]    fetch_pc_q, fetch_pc_d;
  logic               inflight_q, inflight_d;
  logic [XLEN-1:0]    inflight_pc_q, inflight_pc_d;
  logic               kill_q, kill_d;

  // Queue bookkeeping
  logic [C_PTR_W-1:0] head_q, head_d;
  logic [C_PTR_W-1:0] tail_q, tail_d;
  logic [C_CNT_W-1:0] count_q, count_d;

  // Queue storage
  logic [31:0]        ent_inst_q  [DEPTH];
  logic [31:0]        ent_inst_d  [DEPTH];
  logic [XLEN-1:0]    ent_pc_q    [DEPTH];
  logic [XLEN-1:0]    ent_pc_d    [DEPTH];
  logic               ent_taken_q [DEPTH];
  logic               ent_taken_d [DEPTH];
  logic [XLEN-1:0]    ent_pred_q  [DEPTH];
  logic [XLEN-1:0]    ent_pred_d  [DEPTH];

  // Combinational helpers
  logic               w_credit_ok;
  logic               w_enq;
  logic               w_deq;
  logic               w_is_jal;
  logic               w_is_br;
  logic               w_taken;
  logic [XLEN-1:0]    w_imm_j;
  logic [XLEN-1:0]    w_imm_b;
  logic [XLEN-1:0]    w_target;
  logic [XLEN-1:0]    w_pred_pc;

  // Issue, handshake and head outputs; in-flight requests reserve a queue slot
  always_comb begin
    w_credit_ok     = (count_q + C_CNT_W'(inflight_q)) < C_CNT_W'(DEPTH);
    imem_en         = rst & ~flush_flag & w_credit_ok;
    imem_addr       = fetch_pc_q[IMEM_AW+1:2];
    inst_valid      = rst & (count_q != '0);
    inst            = ent_inst_q[head_q];
    inst_pc         = ent_pc_q[head_q];
    inst_pred_taken = ent_taken_q[head_q];
    inst_pred_pc    = ent_pred_q[head_q];
    fq_count        = count_q;
    w_enq           = inflight_q & ~kill_q;
    w_deq           = inst_valid & dec_ready;
  end

  // Static predecode of the returning word (JAL taken, backward branch optional)
  always_comb begin
    w_imm_j   = {{(XLEN-20){imem_rdata[31]}}, imem_rdata[19:12], imem_rdata[20],
                 imem_rdata[30:21], 1'b0};
    w_imm_b   = {{(XLEN-12){imem_rdata[31]}}, imem_rdata[7], imem_rdata[30:25],
                 imem_rdata[11:8], 1'b0};
    w_is_jal  = (imem_rdata[6:0] == C_OP_JAL);
    w_is_br   = (imem_rdata[6:0] == C_OP_BRANCH);
    w_taken   = w_is_jal | (w_is_br & BTFN_EN & imem_rdata[31]);
    w_target  = inflight_pc_q + (w_is_jal ? w_imm_j : w_imm_b);
    w_pred_pc = w_taken ? w_target : (inflight_pc_q + C_PC_STEP);
  end

  // Next-state: flush overrides prediction, enqueue and dequeue
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = imem_en;
    inflight_pc_d = inflight_pc_q;
    kill_d        = 1'b0;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    ent_inst_d    = ent_inst_q;
    ent_pc_d      = ent_pc_q;
    ent_taken_d   = ent_taken_q;
    ent_pred_d    = ent_pred_q;

    if (flush_flag) begin
      // imem_en is low here, so nothing new goes in flight; the response
      // arriving this cycle is simply not enqueued.
      fetch_pc_d = flush_addr & ~XLEN'(3);
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      if (imem_en) begin
        fetch_pc_d    = fetch_pc_q + C_PC_STEP;
        inflight_pc_d = fetch_pc_q;
      end
      if (w_enq) begin
        ent_inst_d[tail_q]  = imem_rdata;
        ent_pc_d[tail_q]    = inflight_pc_q;
        ent_taken_d[tail_q] = w_taken;
        ent_pred_d[tail_q]  = w_pred_pc;
        tail_d              = tail_q + C_PTR_W'(1);
        if (w_taken) begin
          // Redirect; a request issued this cycle is on the wrong path.
          fetch_pc_d = w_target;
          kill_d     = imem_en;
        end
      end
      if (w_deq) begin
        head_d = head_q + C_PTR_W'(1);
      end
      case ({w_enq, w_deq})
        2'b10:   count_d = count_q + C_CNT_W'(1);
        2'b01:   count_d = count_q - C_CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      kill_q        <= 1'b0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        ent_inst_q[i]  <= '0;
        ent_pc_q[i]    <= '0;
        ent_taken_q[i] <= 1'b0;
        ent_pred_q[i]  <= '0;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      kill_q        <= kill_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      ent_inst_q    <= ent_inst_d;
      ent_pc_q      <= ent_pc_d;
      ent_taken_q   <= ent_taken_d;
      ent_pred_q    <= ent_pred_d;
    end
  end

endmodule
`default_nettype wire
